// File: rtl/cache_ctrl_refill.sv
// Cache line refill controller: fetches a missed line critical-word-first and writes data + tag SRAMs.
// Latency: miss accepted at T, mem request at T+1, beats from T+2, tag write after last beat, done/err one cycle later.
// Backpressure: miss_rdy_o low outside IDLE; request held until mem_req_rdy_i; beats consumed only when mem_rsp_vld_i.
module cache_ctrl_refill #(
  parameter int ADDR_WIDTH          = 32,
  parameter int CLINE_SIZE_WORD     = 4,
  parameter int CLINE_ADDR_WIDTH    = 7,
  parameter int CLINE_WORD_WIDTH    = 32,
  parameter int TAG_SRAM_DATA_WIDTH = 32,
  parameter int NUM_WAYS            = 4
) (
  input  logic                                                   clk,
  input  logic                                                   reset,
  // miss request from the pipeline output stage
  input  logic                                                   miss_vld_i,
  output logic                                                   miss_rdy_o,
  input  logic [ADDR_WIDTH-1:0]                                  miss_addr_i,
  // line read request to memory
  output logic                                                   mem_req_vld_o,
  input  logic                                                   mem_req_rdy_i,
  output logic [ADDR_WIDTH-1:0]                                  mem_req_addr_o,
  // response beats
  input  logic                                                   mem_rsp_vld_i,
  output logic                                                   mem_rsp_rdy_o,
  input  logic [CLINE_WORD_WIDTH-1:0]                            mem_rsp_data_i,
  input  logic                                                   mem_rsp_err_i,
  // data SRAM write port
  output logic [NUM_WAYS-1:0]                                    data_web_o,
  output logic [CLINE_ADDR_WIDTH+$clog2(CLINE_SIZE_WORD)-1:0]    data_addr_o,
  output logic [CLINE_WORD_WIDTH-1:0]                            data_wdat_o,
  // tag SRAM write port
  output logic [NUM_WAYS-1:0]                                    tag_web_o,
  output logic [CLINE_ADDR_WIDTH-1:0]                            tag_addr_o,
  output logic [TAG_SRAM_DATA_WIDTH-1:0]                         tag_wdat_o,
  // status
  output logic                                                   pipe_stall_o,
  output logic                                                   done_o,
  output logic                                                   err_o
);

  localparam int OFS  = $clog2(CLINE_SIZE_WORD);
  localparam int CAW  = CLINE_ADDR_WIDTH + OFS;
  localparam int TW   = ADDR_WIDTH - CAW;
  localparam int WAYW = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_FILL = 3'd2,
    S_TAG  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q,  addr_d;   // missed word address, kept for the whole refill
  logic [WAYW-1:0]       way_q,   way_d;    // victim way chosen for this refill
  logic [WAYW-1:0]       vptr_q,  vptr_d;   // round-robin victim pointer
  logic [OFS-1:0]        cnt_q,   cnt_d;    // accepted beat count
  logic                  err_q,   err_d;    // a beat of this refill reported an error

  logic [CLINE_ADDR_WIDTH-1:0]    line_idx;
  logic [OFS-1:0]                 beat_ofs;
  logic [NUM_WAYS-1:0]            way_wen_n;
  logic [TAG_SRAM_DATA_WIDTH-1:0] tag_word;
  logic                           last_beat;

  assign line_idx  = addr_q[CAW-1:OFS];
  // Critical word first: offset wraps naturally in OFS bits.
  assign beat_ofs  = addr_q[OFS-1:0] + cnt_q;
  assign last_beat = (cnt_q == OFS'(CLINE_SIZE_WORD - 1));

  // Active-low write-enable mask selecting only the victim way.
  always_comb begin
    way_wen_n         = '1;
    way_wen_n[way_q]  = 1'b0;
  end

  // Tag word: valid flag in the MSB, address tag in the low bits, zero elsewhere.
  always_comb begin
    tag_word                          = '0;
    tag_word[TAG_SRAM_DATA_WIDTH-1]   = ~err_q;
    tag_word[TW-1:0]                  = addr_q[ADDR_WIDTH-1:CAW];
  end

  // Next-state and output decode; every output idles at its reset value.
  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    way_d          = way_q;
    vptr_d         = vptr_q;
    cnt_d          = cnt_q;
    err_d          = err_q;

    miss_rdy_o     = 1'b0;
    mem_req_vld_o  = 1'b0;
    mem_req_addr_o = addr_q;
    mem_rsp_rdy_o  = 1'b0;
    data_web_o     = '1;
    data_addr_o    = {line_idx, beat_ofs};
    data_wdat_o    = mem_rsp_data_i;
    tag_web_o      = '1;
    tag_addr_o     = line_idx;
    tag_wdat_o     = tag_word;
    pipe_stall_o   = 1'b1;
    done_o         = 1'b0;
    err_o          = 1'b0;

    case (state_q)
      S_IDLE: begin
        miss_rdy_o   = 1'b1;
        pipe_stall_o = 1'b0;
        if (miss_vld_i) begin
          addr_d  = miss_addr_i;
          way_d   = vptr_q;
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = S_REQ;
        end
      end

      S_REQ: begin
        mem_req_vld_o = 1'b1;
        if (mem_req_rdy_i) begin
          state_d = S_FILL;
        end
      end

      S_FILL: begin
        mem_rsp_rdy_o = 1'b1;
        if (mem_rsp_vld_i) begin
          if (mem_rsp_err_i) begin
            // Faulty beat is dropped and the line is closed out as invalid.
            err_d   = 1'b1;
            state_d = S_TAG;
          end else begin
            data_web_o = way_wen_n;
            cnt_d      = cnt_q + OFS'(1);
            if (last_beat) begin
              state_d = S_TAG;
            end
          end
        end
      end

      S_TAG: begin
        tag_web_o = way_wen_n;
        state_d   = S_DONE;
      end

      S_DONE: begin
        done_o  = ~err_q;
        err_o   = err_q;
        vptr_d  = (vptr_q == WAYW'(NUM_WAYS - 1)) ? '0 : vptr_q + WAYW'(1);
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      way_q   <= '0;
      vptr_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      way_q   <= way_d;
      vptr_q  <= vptr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Request must stay put while memory is not ready.
  a_req_stable: assert property (@(posedge clk) disable iff (!reset)
    (mem_req_vld_o && !mem_req_rdy_i) |=> (mem_req_vld_o && $stable(mem_req_addr_o)));

  // At most one way written per cycle, and never data and tag together.
  a_one_way: assert property (@(posedge clk) disable iff (!reset)
    $onehot0(~data_web_o) && $onehot0(~tag_web_o) && !((~data_web_o != '0) && (~tag_web_o != '0)));

  // Completion and abort are mutually exclusive.
  a_done_err: assert property (@(posedge clk) disable iff (!reset) !(done_o && err_o));

endmodule

// File: tb/tb_cache_ctrl_refill.sv
module tb_cache_ctrl_refill;
  localparam int AW  = 32;
  localparam int CLS = 4;
  localparam int CLA = 7;
  localparam int WW  = 32;
  localparam int TSW = 32;
  localparam int NW  = 4;
  localparam int OFS = 2;
  localparam int CAW = CLA + OFS;

  logic clk = 1'b0;
  logic reset;
  logic miss_vld_i, miss_rdy_o;
  logic [AW-1:0] miss_addr_i;
  logic mem_req_vld_o, mem_req_rdy_i;
  logic [AW-1:0] mem_req_addr_o;
  logic mem_rsp_vld_i, mem_rsp_rdy_o, mem_rsp_err_i;
  logic [WW-1:0] mem_rsp_data_i;
  logic [NW-1:0] data_web_o, tag_web_o;
  logic [CAW-1:0] data_addr_o;
  logic [WW-1:0] data_wdat_o;
  logic [CLA-1:0] tag_addr_o;
  logic [TSW-1:0] tag_wdat_o;
  logic pipe_stall_o, done_o, err_o;

  cache_ctrl_refill dut (
    .clk(clk), .reset(reset),
    .miss_vld_i(miss_vld_i), .miss_rdy_o(miss_rdy_o), .miss_addr_i(miss_addr_i),
    .mem_req_vld_o(mem_req_vld_o), .mem_req_rdy_i(mem_req_rdy_i), .mem_req_addr_o(mem_req_addr_o),
    .mem_rsp_vld_i(mem_rsp_vld_i), .mem_rsp_rdy_o(mem_rsp_rdy_o), .mem_rsp_data_i(mem_rsp_data_i),
    .mem_rsp_err_i(mem_rsp_err_i),
    .data_web_o(data_web_o), .data_addr_o(data_addr_o), .data_wdat_o(data_wdat_o),
    .tag_web_o(tag_web_o), .tag_addr_o(tag_addr_o), .tag_wdat_o(tag_wdat_o),
    .pipe_stall_o(pipe_stall_o), .done_o(done_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed { logic [CAW-1:0] a; logic [NW-1:0] web; logic [WW-1:0] d; } dw_t;
  typedef struct packed { logic [CLA-1:0] a; logic [NW-1:0] web; logic [TSW-1:0] d; } tw_t;

  dw_t act_dw[$];
  dw_t exp_dw[$];
  tw_t act_tw[$];
  tw_t exp_tw;
  int  done_c[$], err_c[$], acc_c[$];
  int  nvec = 0, nerr = 0;
  int  m_vptr = 0;
  int  req_bad, rsp_bad;
  logic [WW-1:0] beat_dat [CLS];
  logic [NW-1:0] idle_vals = {NW{1'b1}};

  // Observe every SRAM write, pulse and accepted miss in the middle of the cycle.
  always @(negedge clk) begin
    if (data_web_o !== '1) act_dw.push_back(dw_t'{data_addr_o, data_web_o, data_wdat_o});
    if (tag_web_o !== '1) act_tw.push_back(tw_t'{tag_addr_o, tag_web_o, tag_wdat_o});
    if (done_o === 1'b1) done_c.push_back(cyc);
    if (err_o === 1'b1) err_c.push_back(cyc);
    if (miss_vld_i === 1'b1 && miss_rdy_o === 1'b1) acc_c.push_back(cyc);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time exceeded, required finish before limit");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon;
    act_dw.delete(); act_tw.delete(); done_c.delete(); err_c.delete(); acc_c.delete();
  endtask

  function automatic logic [NW-1:0] way_web(input int w);
    logic [NW-1:0] r;
    r = '1;
    r[w % NW] = 1'b0;
    return r;
  endfunction

  task automatic rand_beats;
    for (int i = 0; i < CLS; i++) beat_dat[i] = $urandom;
  endtask

  // Drives one complete refill and builds the expected writes from the line-fill rules.
  task automatic run_refill(input logic [AW-1:0] addr, input int req_wait, input int max_gap,
                            input int err_beat);
    int line, st, n;
    logic ok, valid;
    req_bad = 0;
    rsp_bad = 0;
    line  = int'(addr >> OFS) % (1 << CLA);
    st    = int'(addr % CLS);
    valid = (err_beat < 0);
    exp_dw.delete();
    for (int i = 0; i < CLS; i++) begin
      if (err_beat >= 0 && i >= err_beat) break;
      exp_dw.push_back(dw_t'{CAW'(line * CLS + (st + i) % CLS), way_web(m_vptr), beat_dat[i]});
    end
    exp_tw = tw_t'{CLA'(line), way_web(m_vptr), (TSW'(valid) << (TSW - 1)) | TSW'(addr >> CAW)};

    miss_vld_i    = 1'b1;
    miss_addr_i   = addr;
    mem_req_rdy_i = (req_wait == 0);
    ok = 1'b0;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      ok = miss_rdy_o;
      tick();
    end
    miss_vld_i  = 1'b0;
    miss_addr_i = $urandom;
    if (!ok) begin
      nvec++; nerr++;
      $display("FAIL accept_timeout: miss_rdy_o=%b, required 1 within 50 cycles", miss_rdy_o);
    end
    for (int i = 0; i <= req_wait; i++) begin
      mem_req_rdy_i = (i == req_wait);
      @(negedge clk);
      if (mem_req_vld_o !== 1'b1 || mem_req_addr_o !== addr) req_bad++;
      tick();
    end
    mem_req_rdy_i = 1'b0;
    n = (err_beat < 0) ? CLS : err_beat + 1;
    for (int b = 0; b < n; b++) begin
      int gap;
      gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      mem_rsp_vld_i = 1'b0;
      for (int g = 0; g < gap; g++) begin
        mem_rsp_data_i = $urandom;
        mem_rsp_err_i  = $urandom_range(1, 0);
        tick();
      end
      mem_rsp_vld_i  = 1'b1;
      mem_rsp_data_i = beat_dat[b];
      mem_rsp_err_i  = (b == err_beat);
      @(negedge clk);
      if (mem_rsp_rdy_o !== 1'b1) rsp_bad++;
      tick();
    end
    mem_rsp_vld_i  = 1'b0;
    mem_rsp_err_i  = 1'b0;
    mem_rsp_data_i = $urandom;
    ok = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin
      tick();
      ok = (done_c.size() + err_c.size()) > 0;
    end
    if (!ok) begin
      nvec++; nerr++;
      $display("FAIL done_timeout: no done_o/err_o pulse, required one within 20 cycles");
    end
    m_vptr = (m_vptr + 1) % NW;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    miss_vld_i = 0; miss_addr_i = '0; mem_req_rdy_i = 0;
    mem_rsp_vld_i = 0; mem_rsp_data_i = '0; mem_rsp_err_i = 0;
    tick(); tick();
    @(negedge clk);
    nvec++;
    if ({miss_rdy_o, mem_req_vld_o, mem_rsp_rdy_o, data_web_o, tag_web_o, pipe_stall_o, done_o, err_o}
        !== {1'b1, 1'b0, 1'b0, idle_vals, idle_vals, 3'b000}) begin
      nerr++;
      $display("FAIL reset_outputs: rdy=%b reqv=%b rspr=%b dweb=%b tweb=%b stall=%b done=%b err=%b, required 1 0 0 1111 1111 0 0 0",
               miss_rdy_o, mem_req_vld_o, mem_rsp_rdy_o, data_web_o, tag_web_o, pipe_stall_o, done_o, err_o);
    end
    tick();
    reset = 1'b1;
    tick();
    @(negedge clk);
    nvec++;
    if ({miss_rdy_o, pipe_stall_o, mem_req_vld_o} !== 3'b100) begin
      nerr++;
      $display("FAIL idle_after_reset: rdy/stall/reqv=%b%b%b, required 100", miss_rdy_o, pipe_stall_o, mem_req_vld_o);
    end
    tick();
    m_vptr = 0;
  endtask

  task automatic test_basic;
    int lat;
    clear_mon();
    beat_dat = '{32'hA, 32'hB, 32'hC, 32'hD};
    run_refill(32'h0000_0102, 0, 0, -1);
    nvec++;
    if (act_dw.size() != exp_dw.size()) begin
      nerr++; $display("FAIL basic_wr_count: got %0d, required %0d", act_dw.size(), exp_dw.size());
    end
    for (int i = 0; i < exp_dw.size(); i++) begin
      dw_t g;
      g = (i < act_dw.size()) ? act_dw[i] : '0;
      nvec++;
      if (g !== exp_dw[i]) begin
        nerr++; $display("FAIL basic_wr%0d: got %h, required %h", i, g, exp_dw[i]);
      end
    end
    nvec++;
    if (act_tw.size() != 1 || act_tw[0] !== exp_tw) begin
      nerr++; $display("FAIL basic_tag: got n=%0d %h, required 1 %h", act_tw.size(), (act_tw.size() > 0) ? act_tw[0] : '0, exp_tw);
    end
    lat = (acc_c.size() == 1 && done_c.size() == 1) ? done_c[0] - acc_c[0] : -1;
    nvec++;
    if (lat != 7 || err_c.size() != 0) begin
      nerr++; $display("FAIL basic_latency: got done at +%0d err=%0d, required +7 err=0", lat, err_c.size());
    end
    nvec++;
    if (req_bad != 0 || rsp_bad != 0) begin
      nerr++; $display("FAIL basic_handshake: req_bad=%0d rsp_bad=%0d, required 0 0", req_bad, rsp_bad);
    end
  endtask

  task automatic test_victim_rotation;
    reset = 1'b0; tick(); reset = 1'b1; tick();
    m_vptr = 0;
    for (int m = 0; m < 5; m++) begin
      logic [NW-1:0] want;
      want = way_web(m % NW);
      clear_mon();
      rand_beats();
      run_refill($urandom, 0, 0, -1);
      nvec++;
      if (act_tw.size() != 1 || act_tw[0] !== exp_tw || exp_tw.web !== want) begin
        nerr++; $display("FAIL victim_tag%0d: got n=%0d %h, required 1 %h", m, act_tw.size(), (act_tw.size() > 0) ? act_tw[0] : '0, exp_tw);
      end
      nvec++;
      if (act_dw.size() != CLS || act_dw[0].web !== want || done_c.size() != 1) begin
        nerr++; $display("FAIL victim_data%0d: got n=%0d web=%b done=%0d, required %0d %b 1", m, act_dw.size(),
                         (act_dw.size() > 0) ? act_dw[0].web : '0, done_c.size(), CLS, want);
      end
    end
  endtask

  task automatic test_stalls;
    for (int m = 0; m < 4; m++) begin
      int bad;
      clear_mon();
      rand_beats();
      run_refill($urandom, (m == 0) ? 3 : int'($urandom_range(4, 1)), 3, -1);
      bad = 0;
      for (int i = 0; i < exp_dw.size(); i++)
        if (i >= act_dw.size() || act_dw[i] !== exp_dw[i]) bad++;
      nvec++;
      if (bad != 0 || act_dw.size() != exp_dw.size()) begin
        nerr++; $display("FAIL stall_writes%0d: got n=%0d bad=%0d, required %0d 0", m, act_dw.size(), bad, exp_dw.size());
      end
      nvec++;
      if (req_bad != 0 || rsp_bad != 0 || act_tw.size() != 1 || act_tw[0] !== exp_tw || done_c.size() != 1) begin
        nerr++; $display("FAIL stall_ctrl%0d: req_bad=%0d rsp_bad=%0d tags=%0d done=%0d, required 0 0 1 1",
                         m, req_bad, rsp_bad, act_tw.size(), done_c.size());
      end
    end
  endtask

  task automatic test_error;
    for (int m = 0; m < 4; m++) begin
      int eb, bad;
      eb = (m == 0) ? 1 : int'($urandom_range(CLS - 1, 0));
      clear_mon();
      rand_beats();
      run_refill($urandom, int'($urandom_range(1, 0)), (m == 0) ? 0 : 2, eb);
      bad = 0;
      for (int i = 0; i < exp_dw.size(); i++)
        if (i >= act_dw.size() || act_dw[i] !== exp_dw[i]) bad++;
      nvec++;
      if (bad != 0 || act_dw.size() != eb) begin
        nerr++; $display("FAIL err_writes%0d: got n=%0d bad=%0d, required %0d 0", m, act_dw.size(), bad, eb);
      end
      nvec++;
      if (act_tw.size() != 1 || act_tw[0] !== exp_tw) begin
        nerr++; $display("FAIL err_tag%0d: got n=%0d %h, required 1 %h", m, act_tw.size(), (act_tw.size() > 0) ? act_tw[0] : '0, exp_tw);
      end
      nvec++;
      if (err_c.size() != 1 || done_c.size() != 0) begin
        nerr++; $display("FAIL err_pulse%0d: got err=%0d done=%0d, required 1 0", m, err_c.size(), done_c.size());
      end
    end
    clear_mon();
    rand_beats();
    run_refill($urandom, 0, 0, -1);
    nvec++;
    if (act_tw.size() != 1 || act_tw[0] !== exp_tw || done_c.size() != 1) begin
      nerr++; $display("FAIL err_recover: got tags=%0d %h done=%0d, required 1 %h 1", act_tw.size(),
                       (act_tw.size() > 0) ? act_tw[0] : '0, done_c.size(), exp_tw);
    end
  endtask

  task automatic test_reset_mid;
    clear_mon();
    mem_req_rdy_i = 1'b1;
    miss_vld_i    = 1'b1;
    miss_addr_i   = $urandom;
    tick();
    miss_vld_i = 1'b0;
    tick();
    mem_req_rdy_i = 1'b0;
    mem_rsp_vld_i = 1'b1; mem_rsp_data_i = $urandom;
    tick();
    mem_rsp_data_i = $urandom;
    tick();
    mem_rsp_vld_i = 1'b0;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    @(negedge clk);
    nvec++;
    if ({miss_rdy_o, mem_req_vld_o, mem_rsp_rdy_o, data_web_o, tag_web_o, pipe_stall_o, done_o, err_o}
        !== {1'b1, 1'b0, 1'b0, idle_vals, idle_vals, 3'b000}) begin
      nerr++;
      $display("FAIL midreset_outputs: rdy=%b reqv=%b rspr=%b dweb=%b tweb=%b stall=%b done=%b err=%b, required 1 0 0 1111 1111 0 0 0",
               miss_rdy_o, mem_req_vld_o, mem_rsp_rdy_o, data_web_o, tag_web_o, pipe_stall_o, done_o, err_o);
    end
    repeat (6) tick();
    nvec++;
    if (act_dw.size() != 2 || act_tw.size() != 0 || done_c.size() != 0 || err_c.size() != 0) begin
      nerr++; $display("FAIL midreset_abandon: writes=%0d tags=%0d done=%0d err=%0d, required 2 0 0 0",
                       act_dw.size(), act_tw.size(), done_c.size(), err_c.size());
    end
    m_vptr = 0;
    clear_mon();
    rand_beats();
    run_refill($urandom, 0, 0, -1);
    nvec++;
    if (act_tw.size() != 1 || act_tw[0] !== exp_tw || act_tw[0].web !== way_web(0)) begin
      nerr++; $display("FAIL midreset_way0: got n=%0d %h, required 1 %h", act_tw.size(), (act_tw.size() > 0) ? act_tw[0] : '0, exp_tw);
    end
  endtask

  task automatic test_miss_held;
    bit rdy_h[int];
    bit st_h[int];
    int bad;
    logic [NW-1:0] w0, w1;
    w0 = way_web(m_vptr);
    w1 = way_web(m_vptr + 1);
    clear_mon();
    mem_req_rdy_i = 1'b1;
    mem_rsp_vld_i = 1'b1; mem_rsp_err_i = 1'b0; mem_rsp_data_i = $urandom;
    miss_vld_i = 1'b1; miss_addr_i = $urandom;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      rdy_h[cyc] = miss_rdy_o;
      st_h[cyc]  = pipe_stall_o;
      tick();
      if (acc_c.size() >= 2) miss_vld_i = 1'b0;
      if (done_c.size() >= 2) break;
    end
    miss_vld_i = 1'b0; mem_req_rdy_i = 1'b0; mem_rsp_vld_i = 1'b0;
    tick();
    nvec++;
    if (acc_c.size() != 2 || acc_c[1] - acc_c[0] != 8) begin
      nerr++; $display("FAIL held_accept: accepts=%0d gap=%0d, required 2 8", acc_c.size(),
                       (acc_c.size() >= 2) ? acc_c[1] - acc_c[0] : -1);
    end
    bad = 0;
    if (acc_c.size() >= 1)
      for (int c = acc_c[0] + 1; c <= acc_c[0] + 7; c++)
        if (!rdy_h.exists(c) || rdy_h[c] != 1'b0 || st_h[c] != 1'b1) bad++;
    nvec++;
    if (bad != 0 || acc_c.size() == 0) begin
      nerr++; $display("FAIL held_stall: %0d cycles with rdy=1 or stall=0, required 0", bad);
    end
    nvec++;
    if (done_c.size() != 2 || act_tw.size() != 2 || act_tw[0].web !== w0 || act_tw[1].web !== w1) begin
      nerr++; $display("FAIL held_ways: done=%0d tags=%0d, required 2 2 with webs %b %b", done_c.size(), act_tw.size(), w0, w1);
    end
    m_vptr = (m_vptr + 2) % NW;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_victim_rotation();
    test_stalls();
    test_error();
    test_reset_mid();
    test_miss_held();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
